pong_game_ctrl: RTL

- Frame-rate game sequencer for the Zybo Pong design.
- Owns game state, lives, BCD score and ball speed. Tells the ball/paddle datapath when to hold the ball at centre, when to move it, and how many pixels per frame.
- Consumes the datapath's end-of-frame, paddle-hit and ball-missed events.
- Sits between the VGA timing/game datapath and the score/lives overlay logic.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/bcd2_sat_counter.sv | 36 +++
 rtl/pong_game_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types, widths and BCD helper for the pong game sequencer
package pong_pkg;

  localparam int SCORE_W     = 8;
  localparam int STEP_W      = 3;
  localparam int LIVES_W     = 2;
  localparam int FRAME_CNT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [SCORE_W-1:0] bcd2_inc_sat(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd2_sat_counter.sv
// rtl/bcd2_sat_counter.sv - two-digit BCD counter with clear, increment and saturation at 99
module bcd2_sat_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] bcd
);

  logic [SCORE_W-1:0] value_q;
  logic [SCORE_W-1:0] value_d;

  // Clear wins over increment so a new game always starts from 00.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = bcd2_inc_sat(value_q);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign bcd = value_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate game sequencer: state, lives, BCD score and ball speed
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES            = 3,
  parameter int SERVE_FRAMES     = 60,
  parameter int MISS_FRAMES      = 63,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int MIN_STEP         = 2,
  parameter int MAX_STEP         = 6
) (
  input  logic               clk25,
  input  logic               Reset,
  input  logic               start_btn,
  input  logic               end_of_frame,
  input  logic               paddle_hit,
  input  logic               ball_missed,
  output logic [2:0]         state,
  output logic               ball_reset,
  output logic               ball_enable,
  output logic [STEP_W-1:0]  ball_step,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               miss_flash,
  output logic               game_over
);

  localparam int HIT_W = $clog2(HITS_PER_SPEEDUP + 1);

  localparam logic [FRAME_CNT_W-1:0] SERVE_LOAD = FRAME_CNT_W'(SERVE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] MISS_LOAD  = FRAME_CNT_W'(MISS_FRAMES);
  localparam logic [STEP_W-1:0]      STEP_MIN   = STEP_W'(MIN_STEP);
  localparam logic [STEP_W-1:0]      STEP_MAX   = STEP_W'(MAX_STEP);
  localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [HIT_W-1:0]       HIT_LAST   = HIT_W'(HITS_PER_SPEEDUP - 1);

  state_e                 state_q, state_d;
  logic [2:0]             sync_q, sync_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [HIT_W-1:0]       hit_cnt_q, hit_cnt_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic                   hit_pend_q, hit_pend_d;
  logic                   miss_pend_q, miss_pend_d;
  logic                   ball_reset_q, ball_reset_d;
  logic                   ball_enable_q, ball_enable_d;
  logic                   miss_flash_q, miss_flash_d;
  logic                   game_over_q, game_over_d;
  logic                   start_rise;
  logic                   hit_eval, miss_eval;
  logic                   score_clr, score_inc;

  // Button synchronizer shift chain; stage 2 is the previous value for edge detect.
  always_comb begin
    sync_d = {sync_q[1:0], start_btn};
  end

  assign start_rise = sync_q[1] & ~sync_q[2];
  assign hit_eval   = hit_pend_q | paddle_hit;
  assign miss_eval  = miss_pend_q | ball_missed;

  // Next-state, counters, sticky event flags and Moore output decode.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    lives_d     = lives_q;
    step_d      = step_q;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    hit_pend_d  = 1'b0;
    miss_pend_d = 1'b0;

    if (state_q == ST_PLAY && !end_of_frame) begin
      hit_pend_d  = hit_eval;
      miss_pend_d = miss_eval;
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d     = ST_SERVE;
          lives_d     = LIVES_INIT;
          step_d      = STEP_MIN;
          hit_cnt_d   = '0;
          frame_cnt_d = SERVE_LOAD;
          score_clr   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (end_of_frame) begin
          if (frame_cnt_q == FRAME_CNT_W'(1)) begin
            state_d = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q - FRAME_CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (end_of_frame) begin
          if (miss_eval) begin
            state_d     = ST_MISS;
            lives_d     = lives_q - LIVES_W'(1);
            frame_cnt_d = MISS_LOAD;
          end else if (hit_eval) begin
            score_inc = 1'b1;
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_d = '0;
              if (step_q < STEP_MAX) begin
                step_d = step_q + STEP_W'(1);
              end
            end else begin
              hit_cnt_d = hit_cnt_q + HIT_W'(1);
            end
          end
        end
      end
      ST_MISS: begin
        if (end_of_frame) begin
          if (frame_cnt_q == FRAME_CNT_W'(1)) begin
            if (lives_q == '0) begin
              state_d = ST_OVER;
            end else begin
              state_d     = ST_SERVE;
              frame_cnt_d = SERVE_LOAD;
              hit_cnt_d   = '0;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - FRAME_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != ST_PLAY) begin
      hit_pend_d  = 1'b0;
      miss_pend_d = 1'b0;
    end

    ball_reset_d  = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
    ball_enable_d = (state_d == ST_PLAY);
    miss_flash_d  = (state_d == ST_MISS);
    game_over_d   = (state_d == ST_OVER);
  end

  // All state and output registers; synchronizer resets high so a held button cannot start a game.
  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      sync_q        <= 3'b111;
      frame_cnt_q   <= '0;
      hit_cnt_q     <= '0;
      lives_q       <= LIVES_INIT;
      step_q        <= STEP_MIN;
      hit_pend_q    <= 1'b0;
      miss_pend_q   <= 1'b0;
      ball_reset_q  <= 1'b1;
      ball_enable_q <= 1'b0;
      miss_flash_q  <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      frame_cnt_q   <= frame_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      lives_q       <= lives_d;
      step_q        <= step_d;
      hit_pend_q    <= hit_pend_d;
      miss_pend_q   <= miss_pend_d;
      ball_reset_q  <= ball_reset_d;
      ball_enable_q <= ball_enable_d;
      miss_flash_q  <= miss_flash_d;
      game_over_q   <= game_over_d;
    end
  end

  bcd2_sat_counter u_score (
    .clk   (clk25),
    .rst   (Reset),
    .clear (score_clr),
    .inc   (score_inc),
    .bcd   (score)
  );

  assign state       = state_q;
  assign ball_reset  = ball_reset_q;
  assign ball_enable = ball_enable_q;
  assign ball_step   = step_q;
  assign lives       = lives_q;
  assign miss_flash  = miss_flash_q;
  assign game_over   = game_over_q;

endmodule
